sat_bin_loader: RTL and testbench



---
 rtl/sat_bin_loader.sv | 195 +++++++++++++++++++
 tb/tb_sat_bin_loader.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_bin_loader.sv
// sat_bin_loader
// Loads one packed SAT problem into sat_bin, starts the solve and returns
// the verdict to the host.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   load_start_i          request a new load (only honoured in IDLE)
//   in_valid_i/in_data_i  problem stream: nb, nv, clause words, var words
//   in_ready_o            stream word accepted when valid & ready
//   apply_ex_o            sat_bin RAMs owned by this loader
//   ram_*_c_ex_o          clause BRAM write port
//   ram_*_v_ex_o          var BRAM write port
//   start_o/bin_info_en_o one-cycle solve start, nb_all_o/nv_all_o held
//   done_i, global_*_i    sat_bin completion and verdict
//   busy_o                load/solve in progress
//   done_o, err_o         completion pulse, header-reject pulse
//   sat_o, unsat_o        verdict latched at done_o
//
// state  | meaning
// IDLE   | waiting for load_start_i
// HDR_NB | taking header word nb
// HDR_NV | taking header word nv
// CHK    | validate T = nb*cmax against both RAM depths
// WR_C   | writing T clause words at addresses 1..T
// WR_V   | writing T var words at addresses 1..T
// TAIL   | last write drains, apply_ex_o still high
// START  | hand back RAMs, issue start pulse
// RUN    | waiting for done_i
module sat_bin_loader #(
  parameter int NUM_CLAUSES_A_BIN  = 8,
  parameter int WIDTH_CLAUSES      = 16,
  parameter int WIDTH_VAR          = 12,
  parameter int ADDR_WIDTH_CLAUSES = 9,
  parameter int ADDR_WIDTH_VAR     = 9,
  parameter int IN_WIDTH           = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start_i,
  input  logic                          in_valid_i,
  input  logic [IN_WIDTH-1:0]           in_data_i,
  output logic                          in_ready_o,
  output logic                          apply_ex_o,
  output logic                          ram_we_c_ex_o,
  output logic [WIDTH_CLAUSES-1:0]      ram_din_c_ex_o,
  output logic [ADDR_WIDTH_CLAUSES-1:0] ram_addr_c_ex_o,
  output logic                          ram_we_v_ex_o,
  output logic [WIDTH_VAR-1:0]          ram_din_v_ex_o,
  output logic [ADDR_WIDTH_VAR-1:0]     ram_addr_v_ex_o,
  output logic                          start_o,
  output logic                          bin_info_en_o,
  output logic [WIDTH_CLAUSES-1:0]      nb_all_o,
  output logic [WIDTH_VAR-1:0]          nv_all_o,
  input  logic                          done_i,
  input  logic                          global_sat_i,
  input  logic                          global_unsat_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          sat_o,
  output logic                          unsat_o,
  output logic                          err_o
);

  // Wide enough that nb*cmax never truncates before the depth check.
  localparam int TW = WIDTH_CLAUSES + $clog2(NUM_CLAUSES_A_BIN) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_NB, S_HDR_NV, S_CHK, S_WR_C, S_WR_V, S_TAIL, S_START, S_RUN
  } state_t;

  state_t r_state, w_next;

  logic [WIDTH_CLAUSES-1:0] r_nb;
  logic [WIDTH_VAR-1:0]     r_nv;
  logic [TW-1:0]            r_total, r_cnt;
  logic                     r_apply, r_we_c, r_we_v, r_start;
  logic                     r_busy, r_done, r_sat, r_unsat, r_err;
  logic [WIDTH_CLAUSES-1:0]      r_din_c;
  logic [ADDR_WIDTH_CLAUSES-1:0] r_addr_c;
  logic [WIDTH_VAR-1:0]          r_din_v;
  logic [ADDR_WIDTH_VAR-1:0]     r_addr_v;

  logic          w_ready, w_accept, w_hdr_bad, w_last;
  logic [TW-1:0] w_total, w_cnt_inc;

  assign w_ready   = (r_state == S_HDR_NB) || (r_state == S_HDR_NV) ||
                     (r_state == S_WR_C)   || (r_state == S_WR_V);
  assign w_accept  = in_valid_i & w_ready;
  assign w_total   = TW'(r_nb) * TW'(NUM_CLAUSES_A_BIN);
  assign w_hdr_bad = (r_nb == '0) ||
                     (w_total > TW'(2**ADDR_WIDTH_CLAUSES - 1)) ||
                     (w_total > TW'(2**ADDR_WIDTH_VAR - 1));
  assign w_cnt_inc = r_cnt + TW'(1);
  assign w_last    = (w_cnt_inc == r_total);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (load_start_i) w_next = S_HDR_NB;
      S_HDR_NB: if (w_accept) w_next = S_HDR_NV;
      S_HDR_NV: if (w_accept) w_next = S_CHK;
      S_CHK:    w_next = w_hdr_bad ? S_IDLE : S_WR_C;
      S_WR_C:   if (w_accept && w_last) w_next = S_WR_V;
      S_WR_V:   if (w_accept && w_last) w_next = S_TAIL;
      S_TAIL:   w_next = S_START;
      S_START:  w_next = S_RUN;
      S_RUN:    if (done_i) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // All outputs are registered, so the visible TAIL/START cycles trail the
  // state by one clock: the TAIL state cycle still shows the last write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nb <= '0; r_nv <= '0; r_total <= '0; r_cnt <= '0;
      r_apply <= 1'b0; r_we_c <= 1'b0; r_we_v <= 1'b0; r_start <= 1'b0;
      r_busy <= 1'b0; r_done <= 1'b0; r_sat <= 1'b0; r_unsat <= 1'b0;
      r_err <= 1'b0;
      r_din_c <= '0; r_addr_c <= '0; r_din_v <= '0; r_addr_v <= '0;
    end else begin
      r_we_c  <= 1'b0;
      r_we_v  <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: if (load_start_i) begin
          r_busy  <= 1'b1;
          r_sat   <= 1'b0;
          r_unsat <= 1'b0;
        end
        S_HDR_NB: if (w_accept) r_nb <= in_data_i[WIDTH_CLAUSES-1:0];
        S_HDR_NV: if (w_accept) r_nv <= in_data_i[WIDTH_VAR-1:0];
        S_CHK: begin
          r_cnt   <= '0;
          r_total <= w_total;
          if (w_hdr_bad) begin
            r_err  <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_apply <= 1'b1;
          end
        end
        S_WR_C: if (w_accept) begin
          r_we_c   <= 1'b1;
          r_addr_c <= w_cnt_inc[ADDR_WIDTH_CLAUSES-1:0];
          r_din_c  <= in_data_i[WIDTH_CLAUSES-1:0];
          r_cnt    <= w_last ? '0 : w_cnt_inc;
        end
        S_WR_V: if (w_accept) begin
          r_we_v   <= 1'b1;
          r_addr_v <= w_cnt_inc[ADDR_WIDTH_VAR-1:0];
          r_din_v  <= in_data_i[WIDTH_VAR-1:0];
          r_cnt    <= w_last ? '0 : w_cnt_inc;
        end
        S_START: begin
          r_apply <= 1'b0;
          r_start <= 1'b1;
        end
        S_RUN: if (done_i) begin
          r_done  <= 1'b1;
          r_sat   <= global_sat_i;
          r_unsat <= global_unsat_i;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o      = w_ready;
  assign apply_ex_o      = r_apply;
  assign ram_we_c_ex_o   = r_we_c;
  assign ram_din_c_ex_o  = r_din_c;
  assign ram_addr_c_ex_o = r_addr_c;
  assign ram_we_v_ex_o   = r_we_v;
  assign ram_din_v_ex_o  = r_din_v;
  assign ram_addr_v_ex_o = r_addr_v;
  assign start_o         = r_start;
  assign bin_info_en_o   = r_start;
  assign nb_all_o        = r_nb;
  assign nv_all_o        = r_nv;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign sat_o           = r_sat;
  assign unsat_o         = r_unsat;
  assign err_o           = r_err;

endmodule

// File: tb/tb_sat_bin_loader.sv
module tb_sat_bin_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_start_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [15:0] in_data_i = '0;
  logic        in_ready_o, apply_ex_o;
  logic        ram_we_c_ex_o, ram_we_v_ex_o;
  logic [15:0] ram_din_c_ex_o;
  logic [8:0]  ram_addr_c_ex_o, ram_addr_v_ex_o;
  logic [11:0] ram_din_v_ex_o;
  logic        start_o, bin_info_en_o;
  logic [15:0] nb_all_o;
  logic [11:0] nv_all_o;
  logic        done_i = 1'b0, global_sat_i = 1'b0, global_unsat_i = 1'b0;
  logic        busy_o, done_o, sat_o, unsat_o, err_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sat_bin_loader dut (
    .clk(clk), .rst(rst), .load_start_i(load_start_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .apply_ex_o(apply_ex_o),
    .ram_we_c_ex_o(ram_we_c_ex_o), .ram_din_c_ex_o(ram_din_c_ex_o),
    .ram_addr_c_ex_o(ram_addr_c_ex_o),
    .ram_we_v_ex_o(ram_we_v_ex_o), .ram_din_v_ex_o(ram_din_v_ex_o),
    .ram_addr_v_ex_o(ram_addr_v_ex_o),
    .start_o(start_o), .bin_info_en_o(bin_info_en_o),
    .nb_all_o(nb_all_o), .nv_all_o(nv_all_o),
    .done_i(done_i), .global_sat_i(global_sat_i), .global_unsat_i(global_unsat_i),
    .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o), .unsat_o(unsat_o),
    .err_o(err_o)
  );

  // ---------------- monitor ----------------
  logic [15:0] stream[$];
  logic [8:0]  c_addr[$];
  logic [15:0] c_data[$];
  logic [8:0]  v_addr[$];
  logic [11:0] v_data[$];
  int   cyc = 0, stall_viol = 0, apply_cnt = 0, start_cnt = 0, err_cnt = 0;
  int   start_cyc = 0, last_wr_cyc = 0;
  logic prev_acc = 1'b0, prev_apply = 1'b0, prev_we = 1'b0;
  logic tail_apply, tail_we, start_apply, start_bie, err_busy;
  logic [15:0] start_nb;
  logic [11:0] start_nv;

  always @(posedge clk) prev_acc = in_valid_i & in_ready_o;

  always @(negedge clk) begin
    cyc++;
    if (ram_we_c_ex_o) begin
      c_addr.push_back(ram_addr_c_ex_o);
      c_data.push_back(ram_din_c_ex_o);
      if (!prev_acc || !apply_ex_o) stall_viol++;
      last_wr_cyc = cyc;
    end
    if (ram_we_v_ex_o) begin
      v_addr.push_back(ram_addr_v_ex_o);
      v_data.push_back(ram_din_v_ex_o);
      if (!prev_acc || !apply_ex_o) stall_viol++;
      last_wr_cyc = cyc;
    end
    if (apply_ex_o) apply_cnt++;
    if (start_o) begin
      start_cnt++;
      start_cyc   = cyc;
      start_nb    = nb_all_o;
      start_nv    = nv_all_o;
      start_bie   = bin_info_en_o;
      start_apply = apply_ex_o;
      tail_apply  = prev_apply;
      tail_we     = prev_we;
    end
    if (err_o) begin
      err_cnt++;
      err_busy = busy_o;
    end
    prev_apply = apply_ex_o;
    prev_we    = ram_we_c_ex_o | ram_we_v_ex_o;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_mon();
    c_addr.delete(); c_data.delete(); v_addr.delete(); v_data.delete();
    stall_viol = 0; apply_cnt = 0; start_cnt = 0; err_cnt = 0;
  endtask

  task automatic build(input int nb, input int nv);
    stream.delete();
    stream.push_back(16'(nb));
    stream.push_back(16'(nv));
    for (int k = 0; k < nb * 8; k++) stream.push_back(16'hC000 + 16'(k));
    for (int k = 0; k < nb * 8; k++) stream.push_back(16'h5A00 + 16'(k));
  endtask

  task automatic pulse_start();
    tick(); load_start_i = 1'b1;
    tick(); load_start_i = 1'b0;
  endtask

  task automatic push_stream(input int n, input bit stall);
    int i = 0;
    int guard = 0;
    bit ph = 1'b0;
    while (i < n && guard < 4000) begin
      tick();
      guard++;
      if (stall && ph) in_valid_i = 1'b0;
      else begin
        in_valid_i = 1'b1;
        in_data_i  = stream[i];
      end
      ph = !ph;
      #1;
      if (in_valid_i && in_ready_o) i++;
    end
    tick();
    in_valid_i = 1'b0;
    total++;
    if (i < n) begin
      bad++;
      $display("FAIL push_stream: accepted %0d words, required %0d", i, n);
    end
  endtask

  task automatic wait_start(input string name);
    int g = 0;
    while (start_cnt == 0 && g < 50) begin tick(); g++; end
    total++;
    if (start_cnt != 1) begin
      bad++;
      $display("FAIL %s start_count: got %0d want 1", name, start_cnt);
    end
  endtask

  task automatic check_writes(input string name, input int t);
    int ec = 0, ev = 0;
    total++;
    if (c_addr.size() != t || v_addr.size() != t) begin
      bad++;
      $display("FAIL %s write_count: clause %0d var %0d want %0d", name,
               c_addr.size(), v_addr.size(), t);
    end else begin
      for (int k = 0; k < t; k++) begin
        if (c_addr[k] !== 9'(k + 1) || c_data[k] !== 16'hC000 + 16'(k)) ec++;
        if (v_addr[k] !== 9'(k + 1) || v_data[k] !== 12'hA00 + 12'(k)) ev++;
      end
      total++;
      if (ec != 0 || ev != 0) begin
        bad++;
        $display("FAIL %s write_seq: clause errs %0d var errs %0d want 0 (first c addr %0d)",
                 name, ec, ev, c_addr[0]);
      end
    end
    total++;
    if (stall_viol != 0) begin
      bad++;
      $display("FAIL %s we_without_accept: got %0d want 0", name, stall_viol);
    end
  endtask

  task automatic check_start(input string name, input int nb, input int nv);
    total++;
    if (start_nb !== 16'(nb) || start_nv !== 12'(nv) || start_bie !== 1'b1) begin
      bad++;
      $display("FAIL %s start_info: nb %0d nv %0d bie %b want %0d %0d 1",
               name, start_nb, start_nv, start_bie, nb, nv);
    end
    total++;
    if (start_cyc - last_wr_cyc != 2 || tail_apply !== 1'b1 || tail_we !== 1'b0 ||
        start_apply !== 1'b0) begin
      bad++;
      $display("FAIL %s tail: gap %0d tail_apply %b tail_we %b start_apply %b want 2 1 0 0",
               name, start_cyc - last_wr_cyc, tail_apply, tail_we, start_apply);
    end
  endtask

  task automatic finish_run(input bit s, input bit u);
    tick(); done_i = 1'b1; global_sat_i = s; global_unsat_i = u;
    tick(); done_i = 1'b0; global_sat_i = 1'b0; global_unsat_i = 1'b0;
    total++;
    if (done_o !== 1'b1 || sat_o !== s || unsat_o !== u || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL finish_run: done %b sat %b unsat %b busy %b want 1 %b %b 0",
               done_o, sat_o, unsat_o, busy_o, s, u);
    end
  endtask

  task automatic full_load(input string name, input int nb, input int nv, input bit stall);
    clear_mon();
    pulse_start();
    build(nb, nv);
    push_stream(stream.size(), stall);
    wait_start(name);
    check_writes(name, nb * 8);
    check_start(name, nb, nv);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    total++;
    if ({in_ready_o, apply_ex_o, ram_we_c_ex_o, ram_we_v_ex_o, start_o, bin_info_en_o,
         busy_o, done_o, sat_o, unsat_o, err_o} !== 11'b0 ||
        nb_all_o !== 16'd0 || nv_all_o !== 12'd0 || ram_addr_c_ex_o !== 9'd0 ||
        ram_din_c_ex_o !== 16'd0 || ram_addr_v_ex_o !== 9'd0 || ram_din_v_ex_o !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs: some output nonzero (ready %b apply %b busy %b nb %0d)",
               in_ready_o, apply_ex_o, busy_o, nb_all_o);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_mon();
    pulse_start();
    total++;
    if (busy_o !== 1'b1) begin
      bad++; $display("FAIL basic busy: got %b want 1", busy_o);
    end
    build(2, 5);
    push_stream(34, 1'b0);
    total++;
    if (in_ready_o !== 1'b0) begin
      bad++; $display("FAIL basic ready_after_34: got %b want 0", in_ready_o);
    end
    wait_start("basic");
    check_writes("basic", 16);
    check_start("basic", 2, 5);
    finish_run(1'b1, 1'b0);
  endtask

  task automatic test_stall();
    full_load("stall", 2, 5, 1'b1);
    finish_run(1'b0, 1'b0);
  endtask

  task automatic test_nb_zero();
    clear_mon();
    pulse_start();
    build(0, 5);
    push_stream(2, 1'b0);
    for (int g = 0; g < 5; g++) tick();
    total++;
    if (err_cnt != 1 || err_busy !== 1'b0) begin
      bad++; $display("FAIL nb_zero err: count %0d busy %b want 1 0", err_cnt, err_busy);
    end
    total++;
    if (apply_cnt != 0 || c_addr.size() != 0 || v_addr.size() != 0) begin
      bad++;
      $display("FAIL nb_zero no_write: apply cycles %0d writes %0d want 0 0",
               apply_cnt, c_addr.size() + v_addr.size());
    end
    full_load("after_err", 1, 3, 1'b0);
    finish_run(1'b1, 1'b0);
  endtask

  task automatic test_bounds();
    clear_mon();
    pulse_start();
    build(64, 1);
    push_stream(2, 1'b0);
    for (int g = 0; g < 5; g++) tick();
    total++;
    if (err_cnt != 1 || apply_cnt != 0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL nb64 err: count %0d apply %0d busy %b want 1 0 0",
               err_cnt, apply_cnt, busy_o);
    end
    full_load("nb63", 63, 200, 1'b0);
    total++;
    if (c_addr.size() != 504 || c_addr[503] !== 9'd504 || v_addr[503] !== 9'd504) begin
      bad++; $display("FAIL nb63 last_addr: size %0d want 504", c_addr.size());
    end
    finish_run(1'b0, 1'b1);
  endtask

  task automatic test_verdict();
    full_load("verdict", 1, 1, 1'b0);
    finish_run(1'b0, 1'b1);
    tick();
    total++;
    if (done_o !== 1'b0 || unsat_o !== 1'b1 || sat_o !== 1'b0) begin
      bad++;
      $display("FAIL verdict hold: done %b unsat %b sat %b want 0 1 0", done_o, unsat_o, sat_o);
    end
    pulse_start();
    total++;
    if (sat_o !== 1'b0 || unsat_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL verdict clear: sat %b unsat %b busy %b want 0 0 1", sat_o, unsat_o, busy_o);
    end
    // done_i outside RUN (here HDR_NB) must not complete the load
    tick(); done_i = 1'b1; global_sat_i = 1'b1;
    tick(); done_i = 1'b0; global_sat_i = 1'b0;
    total++;
    if (done_o !== 1'b0 || sat_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL done_ignored: done %b sat %b busy %b want 0 0 1", done_o, sat_o, busy_o);
    end
    clear_mon();
    build(1, 4);
    push_stream(stream.size(), 1'b0);
    wait_start("after_ignored");
    check_writes("after_ignored", 8);
    finish_run(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    clear_mon();
    pulse_start();
    build(2, 5);
    push_stream(23, 1'b0);
    rst = 1'b0;
    #1;
    total++;
    if ({apply_ex_o, ram_we_c_ex_o, ram_we_v_ex_o, in_ready_o, busy_o, start_o} !== 6'b0 ||
        nb_all_o !== 16'd0 || ram_addr_v_ex_o !== 9'd0) begin
      bad++;
      $display("FAIL reset_mid outputs: apply %b we_v %b ready %b busy %b nb %0d want all 0",
               apply_ex_o, ram_we_v_ex_o, in_ready_o, busy_o, nb_all_o);
    end
    tick(); tick();
    rst = 1'b1;
    for (int g = 0; g < 6; g++) tick();
    total++;
    if (start_cnt != 0 || in_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid idle: starts %0d ready %b want 0 0", start_cnt, in_ready_o);
    end
    full_load("after_reset", 2, 5, 1'b0);
    finish_run(1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_nb_zero();
    test_bounds();
    test_verdict();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
